// File: rtl/sirv_aon_pin_debounce.sv
// Always-on wake pin front end: synchroniser, stable-time debouncer and edge pulses
// that feed the d/en write port of a downstream sticky flag.
module sirv_aon_pin_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             io_pin_async,
    input  logic             io_cfg_en,
    input  logic             io_cfg_pol,
    input  logic [CNT_W-1:0] io_cfg_thresh,
    input  logic             io_clear,
    output logic             io_level,
    output logic             io_rise,
    output logic             io_fall,
    output logic             io_d,
    output logic             io_en,
    output logic [1:0]       dbg_state
);

    // dbg_state encoding: 0 = LOW, 1 = CHK_H, 2 = HIGH, 3 = CHK_L
    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_CHK_H = 2'd1,
        ST_HIGH  = 2'd2,
        ST_CHK_L = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   clr_q;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_pin_async};
        end
    end

    // Polarity-corrected sample: 1 means the pin is in its active level.
    assign act = sync_q[SYNC_STAGES-1] ^ ~io_cfg_pol;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The >= compare lets a lowered threshold take effect mid-check; cnt stops at T.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!io_cfg_en) begin
            state_d = ST_LOW;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_LOW: begin
                    if (act) begin
                        state_d = ST_CHK_H;
                        cnt_d   = '0;
                    end
                end
                ST_CHK_H: begin
                    if (!act) begin
                        state_d = ST_LOW;
                    end else if (cnt_q >= io_cfg_thresh) begin
                        state_d = ST_HIGH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!act) begin
                        state_d = ST_CHK_L;
                        cnt_d   = '0;
                    end
                end
                ST_CHK_L: begin
                    if (act) begin
                        state_d = ST_HIGH;
                    end else if (cnt_q >= io_cfg_thresh) begin
                        state_d = ST_LOW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        level_d = (state_d == ST_HIGH) || (state_d == ST_CHK_L);
        rise_d  = io_cfg_en && (state_q == ST_CHK_H) && (state_d == ST_HIGH);
        fall_d  = io_cfg_en && (state_q == ST_CHK_L) && (state_d == ST_LOW);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            clr_q   <= io_clear;
        end
    end

    // Flag write port: io_en is a one-cycle write strobe with no back-pressure; io_d is the
    // value written. A rise sets the flag and wins over a same-cycle clear.
    assign io_level  = level_q;
    assign io_rise   = rise_q;
    assign io_fall   = fall_q;
    assign io_en     = rise_q | clr_q;
    assign io_d      = rise_q;
    assign dbg_state = state_q;

endmodule
